// File: rtl/gcd_controller.sv
// gcd_controller
//   Control FSM for the subtraction-based GCD unit. It drives the datapath
//   control word and reads the datapath's combinational zero/neg flags in the
//   same cycle. It also sequences the two operand loads over data_in and gives
//   the host a start/busy/done handshake.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-low reset
//   start      in   job request, sampled only in IDLE
//   zero_flag  in   datapath ALU result == 0
//   neg_flag   in   datapath ALU result bit 7
//   CW         out  16-bit datapath control word
//                   [0] A_WE, [1] B_WE, [2] A_SRC, [3] B_SRC,
//                   [5:4] ALU_OP, [6] OUT_EN, [15:7] always 0
//   opnd_sel   out  operand the host must present on data_in (0 = A, 1 = B)
//   busy       out  job in progress (LOAD_A through OUT_A/OUT_B)
//   done       out  one-cycle pulse; datapath data_out holds the result
//   err        out  iteration limit hit; sticky until next accepted start
module gcd_controller #(
  parameter int unsigned MAX_ITER = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        zero_flag,
  input  logic        neg_flag,
  output logic [15:0] CW,
  output logic        opnd_sel,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_A = 4'd1;
  localparam logic [3:0] S_LOAD_B = 4'd2;
  localparam logic [3:0] S_CHK_A  = 4'd3;
  localparam logic [3:0] S_CHK_B  = 4'd4;
  localparam logic [3:0] S_CMP    = 4'd5;
  localparam logic [3:0] S_SUB_AB = 4'd6;
  localparam logic [3:0] S_SUB_BA = 4'd7;
  localparam logic [3:0] S_OUT_A  = 4'd8;
  localparam logic [3:0] S_OUT_B  = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;
  localparam logic [3:0] S_ERROR  = 4'd11;

  localparam logic [1:0] OP_PASS_A = 2'b00;
  localparam logic [1:0] OP_A_SUB_B = 2'b01;
  localparam logic [1:0] OP_B_SUB_A = 2'b10;
  localparam logic [1:0] OP_PASS_B = 2'b11;

  localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);

  logic [3:0] state;
  logic [3:0] state_next;
  logic [7:0] iter;
  logic       iter_full;

  assign iter_full = (iter == ITER_LIMIT);

  // The limit test is made in CMP, where the decision to subtract is taken.
  // The bad subtraction is replaced by ERROR, so no write ever happens on the
  // overflowing iteration and the control word stays a pure state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LOAD_A;
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B: state_next = S_CHK_A;
      S_CHK_A:  state_next = zero_flag ? S_OUT_B : S_CHK_B;
      S_CHK_B:  state_next = zero_flag ? S_OUT_A : S_CMP;
      S_CMP: begin
        if (zero_flag)      state_next = S_OUT_A;
        else if (iter_full) state_next = S_ERROR;
        else if (neg_flag)  state_next = S_SUB_BA;
        else                state_next = S_SUB_AB;
      end
      S_SUB_AB: state_next = S_CMP;
      S_SUB_BA: state_next = S_CMP;
      S_OUT_A:  state_next = S_DONE;
      S_OUT_B:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      S_ERROR:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      iter  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        iter <= '0;
        err  <= 1'b0;
      end else if (state == S_SUB_AB || state == S_SUB_BA) begin
        iter <= iter + 8'd1;
      end
      if (state_next == S_ERROR) err <= 1'b1;
    end
  end

  always_comb begin
    CW       = '0;
    opnd_sel = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_LOAD_A: begin
        CW[0] = 1'b1;
        busy  = 1'b1;
      end
      S_LOAD_B: begin
        CW[1]    = 1'b1;
        opnd_sel = 1'b1;
        busy     = 1'b1;
      end
      S_CHK_A: begin
        CW[5:4] = OP_PASS_A;
        busy    = 1'b1;
      end
      S_CHK_B: begin
        CW[5:4] = OP_PASS_B;
        busy    = 1'b1;
      end
      S_CMP: begin
        CW[5:4] = OP_A_SUB_B;
        busy    = 1'b1;
      end
      S_SUB_AB: begin
        CW[0]   = 1'b1;
        CW[2]   = 1'b1;
        CW[5:4] = OP_A_SUB_B;
        busy    = 1'b1;
      end
      S_SUB_BA: begin
        CW[1]   = 1'b1;
        CW[3]   = 1'b1;
        CW[5:4] = OP_B_SUB_A;
        busy    = 1'b1;
      end
      S_OUT_A: begin
        CW[5:4] = OP_PASS_A;
        CW[6]   = 1'b1;
        busy    = 1'b1;
      end
      S_OUT_B: begin
        CW[5:4] = OP_PASS_B;
        CW[6]   = 1'b1;
        busy    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller
//   Two controllers (MAX_ITER 255 and 10), each paired with a small
//   behavioural GCD datapath. Jobs are checked against an arithmetic GCD and
//   subtraction-count reference for result, latency, err/done and the
//   per-cycle control-word invariants.
module tb_gcd_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  start;
  logic [7:0]  opa [2];
  logic [7:0]  opb [2];
  logic [15:0] cw_v [2];
  logic [7:0]  dout_v [2];
  logic [1:0]  busy_v, done_v, err_v, sel_v;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] cw_at6;

  for (genvar g = 0; g < 2; g++) begin : ch
    logic [7:0]  a_r, b_r, dout_r, alu, din;
    logic        zf, nf, sel, bsy, dn, er;
    logic [15:0] cw;

    gcd_controller #(.MAX_ITER(g == 0 ? 255 : 10)) dut (
      .clk(clk), .reset(rst_n), .start(start[g]),
      .zero_flag(zf), .neg_flag(nf), .CW(cw),
      .opnd_sel(sel), .busy(bsy), .done(dn), .err(er)
    );

    always_comb begin
      case (cw[5:4])
        2'b00:   alu = a_r;
        2'b01:   alu = a_r - b_r;
        2'b10:   alu = b_r - a_r;
        default: alu = b_r;
      endcase
    end
    assign zf  = (alu == 8'd0);
    assign nf  = alu[7];
    assign din = sel ? opb[g] : opa[g];

    always @(posedge clk) begin
      if (cw[0]) a_r <= cw[2] ? alu : din;
      if (cw[1]) b_r <= cw[3] ? alu : din;
      if (cw[6]) dout_r <= alu;
    end

    assign cw_v[g]   = cw;
    assign dout_v[g] = dout_r;
    assign busy_v[g] = bsy;
    assign done_v[g] = dn;
    assign err_v[g]  = er;
    assign sel_v[g]  = sel;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int nsub_ref(input int a, input int b);
    int x = a, y = b, n = 0;
    while (x != 0 && y != 0 && x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
      n++;
    end
    return n;
  endfunction

  function automatic int lim_of(input int s);
    return (s == 0) ? 255 : 10;
  endfunction

  // Issues one job on channel s. exp_wait is the number of edges with start
  // high before the job begins (1 when chaining out of DONE with start held).
  task automatic run_job(input int s, input int a, input int b, input bit hold, input int exp_wait);
    int waited = 0;
    int cyc;
    int exp_cyc;
    bit bad = 0;
    bit exp_err;
    int n = nsub_ref(a, b);

    exp_err = (a != 0 && b != 0 && n > lim_of(s));
    if (a == 0)      exp_cyc = 5;
    else if (b == 0) exp_cyc = 6;
    else if (exp_err) exp_cyc = 2 * lim_of(s) + 6;
    else             exp_cyc = 2 * n + 7;

    opa[s] = 8'(a);
    opb[s] = 8'(b);
    start[s] = 1'b1;
    while (waited < 4) begin
      @(posedge clk); #1;
      if (!hold) start[s] = 1'b0;
      if (busy_v[s]) break;
      waited++;
    end
    check_eq("start_wait", waited, exp_wait);
    check_eq("err_clear_on_start", err_v[s], 1'b0);

    for (cyc = 1; cyc < 600; cyc++) begin
      if (cw_v[s][15:7] != 9'd0) bad = 1;
      if (sel_v[s] != (cyc == 2)) bad = 1;
      if (cyc == 6) cw_at6 = cw_v[s];
      if (!busy_v[s]) break;
      @(posedge clk); #1;
    end

    check_eq("moore_outputs", bad, 1'b0);
    check_eq("latency", cyc, exp_cyc);
    if (exp_err) begin
      check_eq("err_set", err_v[s], 1'b1);
      check_eq("no_done_on_err", done_v[s], 1'b0);
    end else begin
      check_eq("done", done_v[s], 1'b1);
      check_eq("result", dout_v[s], gcd_ref(a, b));
      check_eq("err_low", err_v[s], 1'b0);
    end
    if (!hold) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t;
    int ra, rb;
    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < 2; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_eq("reset_cw", cw_v[s], 16'h0000);
      check_eq("reset_busy", busy_v[s], 1'b0);
      check_eq("reset_done", done_v[s], 1'b0);
      check_eq("reset_err", err_v[s], 1'b0);
      check_eq("reset_sel", sel_v[s], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(0, 12, 8, 0, 0);
    check_eq("cw_sub_ab", cw_at6, 16'h0015);

    // Asynchronous reset in the middle of a subtraction.
    opa[0] = 8'd100;
    opb[0] = 8'd1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    t = 0;
    while (cw_v[0] != 16'h0015 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("reach_sub_ab", cw_v[0] == 16'h0015, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_cw", cw_v[0], 16'h0000);
    check_eq("async_rst_busy", busy_v[0], 1'b0);
    check_eq("async_rst_done", done_v[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(0, 12, 8, 0, 0);

    run_job(0, 0, 9, 0, 0);
    run_job(0, 9, 0, 0, 0);
    run_job(0, 0, 0, 0, 0);
    run_job(0, 127, 1, 0, 0);

    run_job(1, 127, 1, 0, 0);
    check_eq("err_sticky", err_v[1], 1'b1);
    check_eq("err_idle_busy", busy_v[1], 1'b0);
    run_job(1, 6, 4, 0, 0);

    // start held high: ignored while busy and in DONE, then re-triggers.
    run_job(0, 45, 30, 1, 0);
    run_job(0, 21, 14, 1, 1);
    start[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("idle_after_hold", busy_v[0], 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = int'($urandom_range(127, 0));
      rb = int'($urandom_range(127, 0));
      run_job(i % 2, ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
